reg_wb_ctrl: RTL and testbench

Write-side controller for the 32x32 MIPS register file. It merges ALU results and memory-load results into the file's single write port (WE3/A3/WD3), and performs load byte/half selection and sign/zero extension. It also keeps a pending-write scoreboard, so the decode stage can stall on RAW hazards and is blocked from issuing a second write to a register that already has one in flight.

---
 rtl/reg_wb_ctrl_pkg.sv | 42 ++++
 rtl/reg_wb_fifo.sv | 47 ++++
 rtl/reg_wb_ctrl.sv | 146 ++++++++++++++
 tb/tb_reg_wb_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types and helpers for the register-file write-back controller.
// Holds load-size encodings, the queued ALU result record and the load extender.
package reg_wb_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } ld_size_e;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [REG_DW-1:0] data;
  } wb_t;

  localparam int WB_W = $bits(wb_t);

  // Little-endian lane select; 2'b11 behaves as a full word.
  function automatic logic [REG_DW-1:0] ld_extend(input logic [REG_DW-1:0] raw,
                                                  input logic [1:0]        size,
                                                  input logic              sgn,
                                                  input logic [1:0]        off);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [REG_DW-1:0] r;
    b = raw[{off, 3'b000} +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    if (size == SZ_BYTE) begin
      r = {{24{sgn & b[7]}}, b};
    end else if (size == SZ_HALF) begin
      r = {{16{sgn & h[15]}}, h};
    end else begin
      r = raw;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_wb_fifo.sv
// Registered synchronous FIFO for queued ALU results; pop data is the current head.
// No bypass: a pushed entry becomes visible one cycle later; push ignored when full.
module reg_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop_dat_o = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[PW-1:0]] <= push_dat_i;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (pop_i && !empty_o) begin
        rd_q <= rd_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Merges queued ALU results and unbuffered loads into the register-file write port, with RAW scoreboard.
// Load->WE3 one cycle, ALU->WE3 two cycles minimum; ALU FIFO full drops alu_ready, forced ALU turn drops ld_ready.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_dst,
  output logic              iss_ready,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_dst,
  input  logic [REG_DW-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_dst,
  input  logic [REG_DW-1:0] ld_data,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        ld_off,
  output logic              WE3,
  output logic [REG_AW-1:0] A3,
  output logic [REG_DW-1:0] WD3,
  input  logic [REG_AW-1:0] q_rs,
  input  logic [REG_AW-1:0] q_rt,
  output logic              stall_rs,
  output logic              stall_rt,
  output logic [31:0]       busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  wb_t               alu_in;
  wb_t               alu_head;
  wb_t               win;
  logic              fifo_full;
  logic              fifo_empty;
  logic              alu_push;
  logic              alu_pop;
  logic              force_alu;
  logic              ld_win;
  logic              win_vld;
  logic [SW-1:0]     starve_q;
  logic [SW-1:0]     starve_d;
  logic              we3_q;
  logic              we3_d;
  logic [REG_AW-1:0] a3_q;
  logic [REG_AW-1:0] a3_d;
  logic [REG_DW-1:0] wd3_q;
  logic [REG_DW-1:0] wd3_d;
  logic [31:0]       busy_q;
  logic [31:0]       busy_d;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;

  assign alu_in    = {alu_dst, alu_data};
  assign alu_ready = ~fifo_full;
  assign alu_push  = alu_valid & alu_ready;

  reg_wb_fifo #(
    .WIDTH (WB_W),
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (alu_push),
    .push_dat_i (alu_in),
    .pop_i      (alu_pop),
    .pop_dat_o  (alu_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Loads cannot wait, so they win unless the ALU head has lost STARVE_LIMIT times in a row.
  always_comb begin
    force_alu = ~fifo_empty && (starve_q == STARVE_MAX);
    ld_win    = ld_valid & ~force_alu;
    ld_ready  = ~force_alu;
    alu_pop   = ~fifo_empty & ~ld_win;
    win_vld   = ld_win | alu_pop;

    win = alu_head;
    if (ld_win) begin
      win.dst  = ld_dst;
      win.data = ld_extend(ld_data, ld_size, ld_signed, ld_off);
    end

    starve_d = starve_q;
    if (fifo_empty || alu_pop) begin
      starve_d = '0;
    end else if (ld_win) begin
      starve_d = starve_q + STARVE_ONE;
    end
  end

  always_comb begin
    we3_d = win_vld && (win.dst != REG_ZERO);
    a3_d  = win_vld ? win.dst  : a3_q;
    wd3_d = win_vld ? win.data : wd3_q;
  end

  assign iss_ready = ~busy_q[iss_dst];
  assign stall_rs  = busy_q[q_rs];
  assign stall_rt  = busy_q[q_rt];

  // A new issue to the register being written this cycle must stay pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && iss_ready && (iss_dst != REG_ZERO)) begin
      set_vec[iss_dst] = 1'b1;
    end
    if (we3_q) begin
      clr_vec[a3_q] = 1'b1;
    end
    busy_d = ((busy_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
    end
  end

  assign WE3  = we3_q;
  assign A3   = a3_q;
  assign WD3  = wd3_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: queue-based reference model, load-extension vector table,
// directed multi-cycle sequences and a randomized phase.
module tb_reg_wb_ctrl;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_dst;
  logic        iss_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_dst;
  logic [31:0] ld_data;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [1:0]  ld_off;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        stall_rs;
  logic        stall_rt;
  logic [31:0] busy;

  always #5 clk = ~clk;

  reg_wb_ctrl #(
    .ALU_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dst   (alu_dst),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_dst    (ld_dst),
    .ld_data   (ld_data),
    .ld_size   (ld_size),
    .ld_signed (ld_signed),
    .ld_off    (ld_off),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .q_rs      (q_rs),
    .q_rt      (q_rt),
    .stall_rs  (stall_rs),
    .stall_rt  (stall_rt),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_proto  = 0;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [4:0]  dst;
    logic [31:0] exp_wd;
  } ld_vec_t;

  ent_t        m_q[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] off);
    int unsigned v;
    if (size == 2'b00) begin
      v = (raw >> (8 * off)) & 32'hFF;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (raw >> (16 * off[1])) & 32'hFFFF;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_a3     = '0;
    m_wd     = '0;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  // One clock cycle: check handshake outputs, advance the model, check registered outputs.
  task automatic step();
    bit          force_alu;
    bit          have;
    bit          acc;
    logic [4:0]  wdst;
    logic [31:0] wdat;
    logic [31:0] nb;
    ent_t        e;
    #1;
    force_alu = (m_q.size() > 0) && (m_starve == LIMIT);
    acc       = alu_valid && (m_q.size() < DEPTH);
    chk("alu_ready", alu_ready, (m_q.size() < DEPTH));
    chk("ld_ready",  ld_ready,  !force_alu);
    chk("iss_ready", iss_ready, !m_busy[iss_dst]);
    chk("stall_rs",  stall_rs,  m_busy[q_rs]);
    chk("stall_rt",  stall_rt,  m_busy[q_rt]);

    nb = m_busy;
    if (m_we) nb[m_a3] = 1'b0;
    if (iss_valid && !m_busy[iss_dst] && iss_dst != 0) nb[iss_dst] = 1'b1;

    have = 0; wdst = '0; wdat = '0;
    if (force_alu) begin
      e = m_q.pop_front();
      have = 1; wdst = e.dst; wdat = e.data;
      m_starve = 0;
    end else if (ld_valid) begin
      have = 1; wdst = ld_dst; wdat = ref_load(ld_data, ld_size, ld_signed, ld_off);
      m_starve = (m_q.size() > 0) ? m_starve + 1 : 0;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      have = 1; wdst = e.dst; wdat = e.data;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end

    if (have) begin
      if (wdst != 0 && !m_busy[wdst]) n_proto++;
      m_we = (wdst != 0);
      m_a3 = wdst;
      m_wd = wdat;
    end else begin
      m_we = 1'b0;
    end
    m_busy = nb;
    if (acc) m_q.push_back('{alu_dst, alu_data});

    @(posedge clk);
    #1;
    chk("WE3",  WE3,  m_we);
    chk("A3",   A3,   m_a3);
    chk("WD3",  WD3,  m_wd);
    chk("busy", busy, m_busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_vec_t vecs[9];
    vecs[0] = '{32'h1280_3456, 2'b00, 1'b1, 2'd2, 5'd3,  32'hFFFF_FF80};
    vecs[1] = '{32'h1280_3456, 2'b00, 1'b0, 2'd2, 5'd3,  32'h0000_0080};
    vecs[2] = '{32'h1280_3456, 2'b01, 1'b1, 2'd2, 5'd3,  32'h0000_1280};
    vecs[3] = '{32'h1234_8001, 2'b01, 1'b1, 2'd1, 5'd4,  32'hFFFF_8001};
    vecs[4] = '{32'h89AB_CDEF, 2'b10, 1'b1, 2'd3, 5'd6,  32'h89AB_CDEF};
    vecs[5] = '{32'hCAFE_F00D, 2'b11, 1'b1, 2'd1, 5'd7,  32'hCAFE_F00D};
    vecs[6] = '{32'h0000_00FF, 2'b00, 1'b0, 2'd0, 5'd9,  32'h0000_00FF};
    vecs[7] = '{32'hA500_0000, 2'b00, 1'b1, 2'd3, 5'd10, 32'hFFFF_FFA5};
    vecs[8] = '{32'hF00D_1234, 2'b01, 1'b0, 2'd3, 5'd12, 32'h0000_F00D};

    reset = 1'b1;
    idle();
    iss_dst = '0; alu_dst = '0; alu_data = '0; ld_dst = '0; ld_data = '0;
    ld_size = '0; ld_signed = 1'b0; ld_off = '0; q_rs = '0; q_rt = '0;
    model_reset();
    #1;
    chk("rst_WE3", WE3, 0);
    chk("rst_A3", A3, 0);
    chk("rst_WD3", WD3, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ALU path latency and scoreboard clear
    iss_valid = 1'b1; iss_dst = 5'd5;
    step();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'h0000_0007;
    step();
    alu_valid = 1'b0;
    chk("alu_c1_we", WE3, 0);
    step();
    chk("alu_c2_we", WE3, 1);
    chk("alu_c2_a3", A3, 5);
    chk("alu_c2_wd", WD3, 7);
    chk("alu_busy5_held", busy[5], 1);
    step();
    chk("alu_busy5_clr", busy[5], 0);

    // load extension table
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1; ld_data = vecs[i].data; ld_size = vecs[i].size;
      ld_signed = vecs[i].sgn; ld_off = vecs[i].off; ld_dst = vecs[i].dst;
      step();
      chk($sformatf("ldvec%0d_we", i), WE3, 1);
      chk($sformatf("ldvec%0d_a3", i), A3, vecs[i].dst);
      chk($sformatf("ldvec%0d_wd", i), WD3, vecs[i].exp_wd);
    end
    idle();
    step();

    // starvation: one queued ALU entry against a continuous load stream
    for (int c = 0; c < 7; c++) begin
      ld_valid = 1'b1; ld_dst = 5'd11; ld_size = 2'b10; ld_data = 32'h1000 + c;
      alu_valid = (c == 0); alu_dst = 5'd20; alu_data = 32'h0000_A1A1;
      #1;
      chk($sformatf("starve_ld_ready_c%0d", c), ld_ready, (c != 5));
      step();
      chk($sformatf("starve_we_c%0d", c), WE3, 1);
      chk($sformatf("starve_a3_c%0d", c), A3, (c == 5) ? 32'd20 : 32'd11);
      chk($sformatf("starve_wd_c%0d", c), WD3, (c == 5) ? 32'h0000_A1A1 : 32'h1000 + c);
    end
    idle();
    step();

    // scoreboard: stall after issue, then clear by writeback
    iss_valid = 1'b1; iss_dst = 5'd8;
    step();
    iss_valid = 1'b0; q_rs = 5'd8; q_rt = 5'd9;
    #1;
    chk("sb_iss_ready8", iss_ready, 0);
    chk("sb_stall_rs", stall_rs, 1);
    chk("sb_stall_rt", stall_rt, 0);
    step();
    alu_valid = 1'b1; alu_dst = 5'd8; alu_data = 32'h88;
    step();
    alu_valid = 1'b0;
    step();
    chk("sb_wb8_we", WE3, 1);
    iss_valid = 1'b1; iss_dst = 5'd8;
    step();
    iss_valid = 1'b0;
    chk("sb_busy8_clr", busy[8], 0);

    // same-edge clear and set of register 8: set wins
    ld_valid = 1'b1; ld_dst = 5'd8; ld_size = 2'b10; ld_data = 32'h8888;
    step();
    ld_valid = 1'b0;
    iss_valid = 1'b1; iss_dst = 5'd8;
    #1;
    chk("sb_same_we", WE3, 1);
    chk("sb_same_iss_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    chk("sb_set_wins", busy[8], 1);

    // destination 0 is consumed without a write
    alu_valid = 1'b1; alu_dst = 5'd0; alu_data = 32'hDEAD_BEEF;
    #1;
    chk("dst0_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_dst = 5'd0;
    #1;
    chk("dst0_iss_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    chk("dst0_we_c2", WE3, 0);
    step();
    chk("dst0_we_c3", WE3, 0);
    chk("dst0_busy0", busy[0], 0);
    chk("dst0_drained", alu_ready, 1);

    // asynchronous reset with a full FIFO and pending registers
    iss_valid = 1'b1; iss_dst = 5'd5;
    step();
    iss_valid = 1'b0;
    ld_valid = 1'b1; ld_dst = 5'd3; ld_size = 2'b10; ld_data = 32'h33;
    alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'h55;
    step();
    alu_dst = 5'd8; alu_data = 32'h99;
    step();
    idle();
    #1;
    chk("mid_busy", busy, 32'h0000_0120);
    chk("mid_full", alu_ready, 0);
    chk("mid_we", WE3, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_WE3", WE3, 0);
    chk("arst_A3", A3, 0);
    chk("arst_WD3", WD3, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_alu_ready", alu_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("arst_no_stale_c%0d", c), WE3, 0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_dst   = 5'($urandom_range(0, 7));
      alu_valid = 1'($urandom_range(0, 1));
      alu_dst   = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_dst    = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      ld_size   = 2'($urandom);
      ld_signed = 1'($urandom);
      ld_off    = 2'($urandom);
      q_rs      = 5'($urandom_range(0, 7));
      q_rt      = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    step();

    $display("note: %0d writebacks targeted registers not marked pending", n_proto);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
